uart_neopixel_io: RTL and testbench

I/O block for the PMOD NeoPixel board. It combines two independent datapaths that share one clock and one reset. The first is an 8N1 UART receiver that turns the serial RX pin into a byte stream of colour values. The second is a WS2812 single-pixel serializer that turns one 24-bit colour into the NeoPixel one-wire waveform. Frame sequencing and pixel colour storage stay in the parent design.

---
 rtl/uart_neopixel_io.sv | 166 ++++++++++++++++
 tb/tb_uart_neopixel_io.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_neopixel_io.sv
// PMOD NeoPixel I/O: 8N1 UART receiver for colour bytes and a single-pixel
// WS2812 serializer, sharing one clock and reset.
module uart_neopixel_io #(
    parameter int CLKS_PER_BIT = 104,
    parameter int T_BIT        = 15,
    parameter int T0H          = 4,
    parameter int T1H          = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       px_valid,
    input  logic [7:0] px_r,
    input  logic [7:0] px_g,
    input  logic [7:0] px_b,
    output logic       px_dout,
    output logic       px_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam int TW = $clog2(T_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(T_BIT - 1);
    localparam logic [TW-1:0] HIGH0  = TW'(T0H);
    localparam logic [TW-1:0] HIGH1  = TW'(T1H);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {PX_IDLE, PX_SEND} px_state_t;

    rx_state_t       rx_state;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_frame_err;

    px_state_t       px_state;
    logic [TW-1:0]   px_cyc;
    logic [4:0]      px_bit;
    logic [23:0]     px_shift;

    // Synchronizer flops idle high so reset release never looks like a start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt       <= '0;
                    rx_frame_err <= 1'b0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // A low stop bit drops the byte and parks here until the line recovers.
                    if (rx_frame_err) begin
                        if (rx_sync)
                            rx_state <= RX_IDLE;
                    end else if (rx_cnt == BIT_LAST) begin
                        if (rx_sync) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // px_cyc is the position within the bit currently on px_dout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            px_state <= PX_IDLE;
            px_cyc   <= '0;
            px_bit   <= '0;
            px_shift <= '0;
            px_dout  <= 1'b0;
            px_busy  <= 1'b0;
        end else begin
            case (px_state)
                PX_IDLE: begin
                    px_dout <= 1'b0;
                    if (px_valid) begin
                        px_shift <= {px_g, px_r, px_b};
                        px_cyc   <= '0;
                        px_bit   <= '0;
                        px_busy  <= 1'b1;
                        px_dout  <= 1'b1;
                        px_state <= PX_SEND;
                    end
                end
                PX_SEND: begin
                    if (px_cyc == T_LAST) begin
                        px_cyc <= '0;
                        if (px_bit == 5'd23) begin
                            px_busy  <= 1'b0;
                            px_dout  <= 1'b0;
                            px_state <= PX_IDLE;
                        end else begin
                            px_bit   <= px_bit + 1'b1;
                            px_shift <= {px_shift[22:0], 1'b0};
                            px_dout  <= 1'b1;
                        end
                    end else begin
                        px_cyc  <= px_cyc + 1'b1;
                        px_dout <= (px_cyc + 1'b1) < (px_shift[23] ? HIGH1 : HIGH0);
                    end
                end
                default: px_state <= PX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_neopixel_io.sv
// Randomized self-checking bench for uart_neopixel_io against a timeline model
// of the UART byte stream and the WS2812 waveform.
module tb_uart_neopixel_io;

    localparam int CPB   = 104;
    localparam int TBIT  = 15;
    localparam int HI0   = 4;
    localparam int HI1   = 9;
    localparam int PXLEN = 24 * TBIT;

    logic       CLK;
    logic       RST;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       px_valid;
    logic [7:0] px_r;
    logic [7:0] px_g;
    logic [7:0] px_b;
    logic       px_dout;
    logic       px_busy;

    int assertCount = 0;
    int failCount   = 0;

    int          cyc     = 0;
    int          mStart  = -1000;
    int          mEnd    = -1000;
    logic [23:0] mWord   = '0;

    logic [7:0]  expByte [0:63];
    int          expC0   [0:63];
    int          expWr   = 0;
    int          expRd   = 0;
    logic [7:0]  modelLast = 8'h00;
    logic        prevValid = 1'b0;

    uart_neopixel_io #(
        .CLKS_PER_BIT(CPB),
        .T_BIT(TBIT),
        .T0H(HI0),
        .T1H(HI1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .rx(rx),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .px_valid(px_valid),
        .px_r(px_r),
        .px_g(px_g),
        .px_b(px_b),
        .px_dout(px_dout),
        .px_busy(px_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            if (failCount <= 40)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Pixel model: a request seen at an edge while the previous pixel has fully
    // ended starts a 360-cycle window whose waveform follows from the captured word.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mStart = -1000;
            mEnd   = -1000;
        end else begin
            cyc++;
            if (cyc > mEnd && px_valid) begin
                mStart = cyc;
                mEnd   = cyc + PXLEN;
                mWord  = {px_g, px_r, px_b};
            end
        end
    end

    always @(negedge CLK) begin
        int   t;
        int   lat;
        logic expBusy;
        logic expDout;
        if (RST) begin
            checkOutput("reset_px_busy", {31'd0, px_busy}, 32'd0);
            checkOutput("reset_px_dout", {31'd0, px_dout}, 32'd0);
            checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
            expRd     = expWr;
            modelLast = 8'h00;
            prevValid = 1'b0;
        end else begin
            expBusy = (cyc >= mStart) && (cyc < mEnd);
            expDout = 1'b0;
            if (expBusy) begin
                t = cyc - mStart;
                expDout = (t % TBIT) < (mWord[23 - t / TBIT] ? HI1 : HI0);
            end
            checkOutput("px_busy", {31'd0, px_busy}, {31'd0, expBusy});
            checkOutput("px_dout", {31'd0, px_dout}, {31'd0, expDout});
            if (rx_valid) begin
                checkOutput("rx_valid_consecutive", {31'd0, prevValid}, 32'd0);
                if (expRd == expWr) begin
                    checkOutput("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
                end else begin
                    lat = cyc - expC0[expRd];
                    checkOutput("rx_byte_value", {24'd0, rx_byte}, {24'd0, expByte[expRd]});
                    checkOutput("rx_latency_window", {31'd0, (lat >= 988 && lat <= 994)}, 32'd1);
                    modelLast = expByte[expRd];
                    expRd++;
                end
            end else if (expRd != expWr && cyc > expC0[expRd] + 994) begin
                checkOutput("rx_valid_missing", {31'd0, rx_valid}, 32'd1);
                expRd++;
            end
            checkOutput("rx_byte_hold", {24'd0, rx_byte}, {24'd0, modelLast});
            prevValid = rx_valid;
        end
    end

    // Must be called #1 after a rising edge; returns aligned the same way.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic expectIt);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        if (expectIt) begin
            expByte[expWr] = b;
            expC0[expWr]   = cyc;
            expWr++;
        end
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge CLK);
            #1;
        end
        rx = 1'b1;
    endtask

    // Must be called at a falling edge; returns at the first falling edge with px_busy low.
    task automatic measurePixel(output int len, output int highs, output logic [23:0] mask);
        int waitN;
        int bitHigh [0:23];
        len = 0; highs = 0; mask = '0; waitN = 0;
        for (int k = 0; k < 24; k++) bitHigh[k] = 0;
        while (!px_busy && waitN < 400) begin
            @(negedge CLK);
            waitN++;
        end
        while (px_busy && len < 1000) begin
            if (px_dout) begin
                highs++;
                if (len / TBIT < 24) bitHigh[len / TBIT]++;
            end
            len++;
            @(negedge CLK);
        end
        for (int k = 0; k < 24; k++)
            if (bitHigh[k] == HI1) mask[k] = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic hold);
        @(posedge CLK); #1;
        px_r = r; px_g = g; px_b = b;
        px_valid = 1'b1;
        if (!hold) begin
            @(posedge CLK); #1;
            px_valid = 1'b0;
        end
    endtask

    task automatic pixelRandom(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            px_valid = ($urandom_range(0, 3) == 0);
            px_r = 8'($urandom);
            px_g = 8'($urandom);
            px_b = 8'($urandom);
        end
        px_valid = 1'b0;
    endtask

    task automatic uartSequence();
        @(posedge CLK); #1;
        sendFrame(8'hA5, 1'b1, 1'b1);
        repeat (30) @(posedge CLK);
        #1;
        checkOutput("rx_byte_after_A5", {24'd0, rx_byte}, 32'h0000_00A5);
        sendFrame(8'h40, 1'b1, 1'b1);
        sendFrame(8'h00, 1'b1, 1'b1);
        sendFrame(8'hFF, 1'b1, 1'b1);
        repeat (30) @(posedge CLK);
        #1;
        checkOutput("rx_byte_after_burst", {24'd0, rx_byte}, 32'h0000_00FF);
        rx = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge CLK);
        #1;
        sendFrame(8'h55, 1'b0, 1'b0);
        repeat (300) @(posedge CLK);
        #1;
        checkOutput("rx_byte_after_errors", {24'd0, rx_byte}, 32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            sendFrame(8'($urandom), 1'b1, 1'b1);
            repeat ($urandom_range(0, 50)) @(posedge CLK);
            #1;
        end
        repeat (1100) @(posedge CLK);
        #1;
    endtask

    initial begin
        int          len1, highs1, len2, highs2, gap;
        logic [23:0] mask1, mask2;

        RST = 1'b1; rx = 1'b1; px_valid = 1'b0;
        px_r = '0; px_g = '0; px_b = '0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("init_rx_byte", {24'd0, rx_byte}, 32'd0);
        checkOutput("init_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("init_px_dout", {31'd0, px_dout}, 32'd0);
        checkOutput("init_px_busy", {31'd0, px_busy}, 32'd0);
        RST = 1'b0;
        repeat (5) @(posedge CLK);

        $display("[TB] single pixel r=40 g=00 b=00");
        applyStimulus(8'h40, 8'h00, 8'h00, 1'b0);
        @(negedge CLK);
        measurePixel(len1, highs1, mask1);
        checkOutput("px1_busy_len", len1, 32'd360);
        checkOutput("px1_high_cycles", highs1, 32'd101);
        checkOutput("px1_one_bits", {8'd0, mask1}, 32'h0000_0200);

        $display("[TB] back-to-back pixels g=FF r=00 b=01");
        repeat (5) @(posedge CLK);
        applyStimulus(8'h00, 8'hFF, 8'h01, 1'b1);
        @(negedge CLK);
        measurePixel(len1, highs1, mask1);
        gap = 0;
        while (!px_busy && gap < 10) begin
            gap++;
            @(negedge CLK);
        end
        px_valid = 1'b0;
        measurePixel(len2, highs2, mask2);
        checkOutput("b2b_len_first", len1, 32'd360);
        checkOutput("b2b_high_first", highs1, 32'd141);
        checkOutput("b2b_bits_first", {8'd0, mask1}, 32'h0080_00FF);
        checkOutput("b2b_gap", gap, 32'd1);
        checkOutput("b2b_len_second", len2, 32'd360);
        checkOutput("b2b_high_second", highs2, 32'd141);
        checkOutput("b2b_bits_second", {8'd0, mask2}, 32'h0080_00FF);

        $display("[TB] random pixels alongside UART traffic");
        fork
            pixelRandom(3000);
            uartSequence();
        join
        repeat (400) @(posedge CLK);

        $display("[TB] reset mid-byte and mid-pixel");
        @(posedge CLK); #1;
        rx = 1'b0;
        repeat (30) @(posedge CLK);
        applyStimulus(8'h12, 8'h34, 8'h56, 1'b0);
        repeat (99) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checkOutput("async_rst_px_dout", {31'd0, px_dout}, 32'd0);
        checkOutput("async_rst_px_busy", {31'd0, px_busy}, 32'd0);
        checkOutput("async_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("async_rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (1300) @(posedge CLK);
        #1;
        checkOutput("post_rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        checkOutput("post_rst_px_busy", {31'd0, px_busy}, 32'd0);
        checkOutput("rx_expect_drained", expWr - expRd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
